lcd_seg_scanner: RTL and testbench

Parametrised LCD segment/common scanner for the Game & Watch CPU cores. It replaces the fixed 4-common, 32-segment display logic embedded in the core. On every common phase it fetches the display nibbles from CPU RAM over a read port, then atomically updates the segment, common and Bs outputs. It adds configurable common and segment counts, blanking that resets the common index, frame-done signalling, and overrun detection.

---
 rtl/lcd_seg_scanner.sv | 195 +++++++++++++++++++
 tb/tb_lcd_seg_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seg_scanner.sv
// LCD segment/common scanner for the Game & Watch CPU cores.
// Every common phase (COM_TICKS tick strobes) it reads NUM_SEG display nibbles from
// CPU RAM, keeps the bit for the selected common of each nibble in a shadow register,
// and then updates the segment, common and Bs outputs together in a single clock.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   tick        one-clk time-base strobe
//   bp_en, bc   backplane enable / blank request, sampled at commit
//   l_reg,y_reg Bs source and mask, sampled at commit
//   ram_rd      read strobe, one clk per address
//   ram_addr    display RAM read address
//   ram_data    read nibble, valid the clk after ram_rd
//   seg_out     segment drive for the current common
//   com_out     one-hot common select
//   bs_out      Bs output for the current common
//   frame_done  one-clk pulse when the last common is committed
//   overrun     sticky: a phase boundary arrived while a fetch was in progress
module lcd_seg_scanner #(
  parameter int unsigned       NUM_COM   = 4,
  parameter int unsigned       NUM_SEG   = 32,
  parameter int unsigned       RAM_AW    = 7,
  parameter logic [RAM_AW-1:0] DISP_BASE = 7'h60,
  parameter int unsigned       COM_TICKS = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                bp_en,
  input  logic                bc,
  input  logic [3:0]          l_reg,
  input  logic [3:0]          y_reg,
  output logic                ram_rd,
  output logic [RAM_AW-1:0]   ram_addr,
  input  logic [3:0]          ram_data,
  output logic [NUM_SEG-1:0]  seg_out,
  output logic [NUM_COM-1:0]  com_out,
  output logic                bs_out,
  output logic                frame_done,
  output logic                overrun
);

  localparam int unsigned CW = (NUM_COM > 1) ? $clog2(NUM_COM) : 1;
  localparam int unsigned JW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int unsigned TW = $clog2(COM_TICKS);

  typedef enum logic [1:0] {StIdle, StFetch, StCommit} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [CW-1:0]       cidx_q, cidx_d;
  logic [CW-1:0]       nidx_q, nidx_d;
  logic [JW-1:0]       rd_j_q, rd_j_d;
  logic                ram_rd_q, ram_rd_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic                cap_q, cap_d;
  logic [JW-1:0]       cap_j_q, cap_j_d;
  logic [NUM_SEG-1:0]  shadow_q, shadow_d;
  logic [NUM_SEG-1:0]  seg_q, seg_d;
  logic [NUM_COM-1:0]  com_q, com_d;
  logic                bs_q, bs_d;
  logic                fd_q, fd_d;
  logic                ovr_q, ovr_d;

  logic                boundary;
  logic [CW-1:0]       nidx_next;
  logic [1:0]          nidx_sel;
  logic [3:0]          bs_vec;

  assign boundary  = tick && (tcnt_q == TW'(COM_TICKS - 1));
  // A blanking commit parks cidx at the last common, so this also restarts at common 0.
  assign nidx_next = (cidx_q == CW'(NUM_COM - 1)) ? '0 : cidx_q + CW'(1);
  assign nidx_sel  = 2'(nidx_q);
  assign bs_vec    = l_reg & ~y_reg;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    cidx_d     = cidx_q;
    nidx_d     = nidx_q;
    rd_j_d     = rd_j_q;
    ram_rd_d   = ram_rd_q;
    ram_addr_d = ram_addr_q;
    cap_d      = 1'b0;
    cap_j_d    = rd_j_q;
    shadow_d   = shadow_q;
    seg_d      = seg_q;
    com_d      = com_q;
    bs_d       = bs_q;
    fd_d       = 1'b0;
    ovr_d      = ovr_q;

    if (tick) begin
      tcnt_d = boundary ? '0 : tcnt_q + TW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (boundary) begin
          state_d    = StFetch;
          nidx_d     = nidx_next;
          ram_rd_d   = 1'b1;
          ram_addr_d = DISP_BASE;
          rd_j_d     = '0;
        end
      end
      StFetch: begin
        if (boundary) begin
          ovr_d = 1'b1;
        end
        // Read issue: the RAM samples ram_rd/ram_addr at the edge; data arrives a clk later.
        if (ram_rd_q) begin
          cap_d   = 1'b1;
          cap_j_d = rd_j_q;
          if (rd_j_q == JW'(NUM_SEG - 1)) begin
            ram_rd_d = 1'b0;
          end else begin
            rd_j_d     = rd_j_q + JW'(1);
            ram_addr_d = ram_addr_q + RAM_AW'(1);
          end
        end
        if (cap_q) begin
          shadow_d[cap_j_q] = ram_data[nidx_sel];
          if (cap_j_q == JW'(NUM_SEG - 1)) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        if (boundary) begin
          ovr_d = 1'b1;
        end
        state_d = StIdle;
        if (bp_en && !bc) begin
          seg_d  = shadow_q;
          com_d  = NUM_COM'(1) << nidx_q;
          bs_d   = bs_vec[nidx_sel];
          cidx_d = nidx_q;
          fd_d   = (nidx_q == CW'(NUM_COM - 1));
        end else begin
          seg_d  = '0;
          com_d  = '0;
          bs_d   = 1'b0;
          cidx_d = CW'(NUM_COM - 1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tcnt_q     <= '0;
      cidx_q     <= CW'(NUM_COM - 1);
      nidx_q     <= '0;
      rd_j_q     <= '0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      cap_q      <= 1'b0;
      cap_j_q    <= '0;
      shadow_q   <= '0;
      seg_q      <= '0;
      com_q      <= '0;
      bs_q       <= 1'b0;
      fd_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      cidx_q     <= cidx_d;
      nidx_q     <= nidx_d;
      rd_j_q     <= rd_j_d;
      ram_rd_q   <= ram_rd_d;
      ram_addr_q <= ram_addr_d;
      cap_q      <= cap_d;
      cap_j_q    <= cap_j_d;
      shadow_q   <= shadow_d;
      seg_q      <= seg_d;
      com_q      <= com_d;
      bs_q       <= bs_d;
      fd_q       <= fd_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ram_rd     = ram_rd_q;
  assign ram_addr   = ram_addr_q;
  assign seg_out    = seg_q;
  assign com_out    = com_q;
  assign bs_out     = bs_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_lcd_seg_scanner.sv
// Testbench for lcd_seg_scanner. Three instances share the clock and tick:
//   u_dut  default parameters, RAM model, commit results checked through a scoreboard
//   u_wrap NUM_SEG=8, DISP_BASE=7'h7C, COM_TICKS=16: read address sequence and wrap
//   u_ovr  NUM_SEG=8, COM_TICKS=2: overrun, and reset while fetching
module tb_lcd_seg_scanner;

  logic clk;
  logic rst, rst_o, tick, bp_en, bc;
  logic [3:0] l_reg, y_reg;

  logic        ram_rd, bs_out, frame_done, overrun;
  logic [6:0]  ram_addr;
  logic [3:0]  ram_data, com_out;
  logic [31:0] seg_out;

  logic        w_ram_rd, w_bs_out, w_frame_done, w_overrun;
  logic [6:0]  w_ram_addr;
  logic [3:0]  w_ram_data, w_com_out;
  logic [7:0]  w_seg_out;

  logic        o_ram_rd, o_bs_out, o_frame_done, o_overrun;
  logic [6:0]  o_ram_addr;
  logic [3:0]  o_ram_data, o_com_out;
  logic [7:0]  o_seg_out;

  assign w_ram_data = 4'h0;
  assign o_ram_data = 4'hF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_seg_scanner u_dut (
    .clk(clk), .rst(rst), .tick(tick), .bp_en(bp_en), .bc(bc),
    .l_reg(l_reg), .y_reg(y_reg), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_data(ram_data), .seg_out(seg_out), .com_out(com_out), .bs_out(bs_out),
    .frame_done(frame_done), .overrun(overrun)
  );

  lcd_seg_scanner #(.NUM_SEG(8), .DISP_BASE(7'h7C), .COM_TICKS(16)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .bp_en(bp_en), .bc(bc),
    .l_reg(l_reg), .y_reg(y_reg), .ram_rd(w_ram_rd), .ram_addr(w_ram_addr),
    .ram_data(w_ram_data), .seg_out(w_seg_out), .com_out(w_com_out), .bs_out(w_bs_out),
    .frame_done(w_frame_done), .overrun(w_overrun)
  );

  lcd_seg_scanner #(.NUM_SEG(8), .COM_TICKS(2)) u_ovr (
    .clk(clk), .rst(rst_o), .tick(tick), .bp_en(bp_en), .bc(bc),
    .l_reg(l_reg), .y_reg(y_reg), .ram_rd(o_ram_rd), .ram_addr(o_ram_addr),
    .ram_data(o_ram_data), .seg_out(o_seg_out), .com_out(o_com_out), .bs_out(o_bs_out),
    .frame_done(o_frame_done), .overrun(o_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Display RAM: even offsets from 0x60 hold 4'b0101, odd offsets hold 0.
  logic [3:0] mem [128];
  initial begin
    for (int j = 0; j < 128; j++) mem[7'(96 + j)] = (j % 2 == 0) ? 4'b0101 : 4'b0000;
  end

  always @(posedge clk) ram_data <= mem[ram_addr];

  function automatic logic [31:0] exp_seg(input logic [1:0] n);
    logic [31:0] s;
    logic [3:0]  v;
    for (int j = 0; j < 32; j++) begin
      v    = mem[7'(96 + j)];
      s[j] = v[n];
    end
    return s;
  endfunction

  typedef struct {
    int unsigned due;
    logic [3:0]  com;
    logic [31:0] seg;
    logic        bs;
    logic        fd;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic [6:0]  addr;
  } rd_t;

  exp_t sb_q[$];
  rd_t  rd_q[$];

  int unsigned cyc     = 0;
  int unsigned tcnt_m  = 0;
  int unsigned tcnt_w  = 0;
  logic [1:0]  cidx_m  = 2'd3;
  int          n_commits = 0;
  int          fd_exp  = 0;
  int          fd_seen = 0;
  logic        started = 1'b0;
  logic [3:0]  last_com = '0;
  logic [31:0] last_seg = '0;
  logic        last_bs  = 1'b0;

  // Reference model: counts ticks, pushes expected commits and read addresses at each
  // phase boundary, then compares against the DUTs 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t       e;
    rd_t        r;
    logic [1:0] nidx;
    logic [3:0] bsv;
    cyc++;
    if (rst) begin
      tcnt_m = 0;
      tcnt_w = 0;
      cidx_m = 2'd3;
    end else if (tick) begin
      if (tcnt_m == 511) begin
        tcnt_m = 0;
        nidx   = cidx_m + 2'd1;
        e.due  = cyc + 34;
        if (bp_en && !bc) begin
          bsv    = l_reg & ~y_reg;
          e.com  = 4'b0001 << nidx;
          e.seg  = exp_seg(nidx);
          e.bs   = bsv[nidx];
          e.fd   = (nidx == 2'd3);
          cidx_m = nidx;
        end else begin
          e.com  = '0;
          e.seg  = '0;
          e.bs   = 1'b0;
          e.fd   = 1'b0;
          cidx_m = 2'd3;
        end
        if (e.fd) fd_exp++;
        sb_q.push_back(e);
      end else begin
        tcnt_m++;
      end
      if (tcnt_w == 15) begin
        tcnt_w = 0;
        for (int j = 0; j < 8; j++) begin
          r.due  = cyc + j;
          r.addr = 7'(7'h7C + j);
          rd_q.push_back(r);
        end
      end else begin
        tcnt_w++;
      end
    end
    #1;
    if (started) begin
      if (frame_done) fd_seen++;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check_val($sformatf("com_%0d", n_commits), 64'(com_out), 64'(e.com));
        check_val($sformatf("seg_%0d", n_commits), 64'(seg_out), 64'(e.seg));
        check_val($sformatf("bs_%0d", n_commits), 64'(bs_out), 64'(e.bs));
        check_val($sformatf("fd_%0d", n_commits), 64'(frame_done), 64'(e.fd));
        last_com = e.com;
        last_seg = e.seg;
        last_bs  = e.bs;
        n_commits++;
      end else if (com_out !== last_com || seg_out !== last_seg || bs_out !== last_bs) begin
        check_val("hold", 64'({com_out, seg_out, bs_out}), 64'({last_com, last_seg, last_bs}));
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r = rd_q.pop_front();
        check_val("wrap_rd", 64'(w_ram_rd), 64'(1));
        check_val("wrap_addr", 64'(w_ram_addr), 64'(r.addr));
      end else if (w_ram_rd !== 1'b0) begin
        check_val("wrap_spurious_rd", 64'(w_ram_rd), 64'(0));
      end
    end
  end

  task automatic wait_commits(input int n, input int budget);
    int k = 0;
    while (n_commits < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_commits < n) check_val($sformatf("timeout_commit_%0d", n), 64'(n_commits), 64'(n));
  endtask

  initial begin
    int k;
    rst = 1'b1; rst_o = 1'b1; tick = 1'b1;
    bp_en = 1'b1; bc = 1'b0; l_reg = 4'b1010; y_reg = 4'b0010;
    repeat (3) @(negedge clk);
    check_val("rst_seg", 64'(seg_out), 64'(0));
    check_val("rst_com", 64'(com_out), 64'(0));
    check_val("rst_bs", 64'(bs_out), 64'(0));
    check_val("rst_ram_rd", 64'(ram_rd), 64'(0));
    check_val("rst_ram_addr", 64'(ram_addr), 64'(0));
    check_val("rst_fd", 64'(frame_done), 64'(0));
    check_val("rst_overrun", 64'(overrun), 64'(0));
    check_val("rst_ovr_overrun", 64'(o_overrun), 64'(0));
    rst = 1'b0; rst_o = 1'b0; started = 1'b1;

    // Boundary every 2 clks against a 10-clk fetch/commit.
    repeat (20) @(negedge clk);
    check_val("ovr_set", 64'(o_overrun), 64'(1));
    k = 0;
    while (o_com_out == 4'b0000 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("ovr_first_com", 64'(o_com_out), 64'(4'b0001));
    check_val("ovr_first_seg", 64'(o_seg_out), 64'(8'hFF));
    repeat (30) @(negedge clk);
    check_val("ovr_sticky", 64'(o_overrun), 64'(1));
    k = 0;
    while (o_ram_rd !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_val("ovr_in_fetch", 64'(o_ram_rd), 64'(1));
    rst_o = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_ram_rd", 64'(o_ram_rd), 64'(0));
    check_val("midrst_ram_addr", 64'(o_ram_addr), 64'(0));
    check_val("midrst_seg", 64'(o_seg_out), 64'(0));
    check_val("midrst_com", 64'(o_com_out), 64'(0));
    check_val("midrst_overrun", 64'(o_overrun), 64'(0));
    @(negedge clk);
    rst_o = 1'b0;

    // Main sequence: one full frame, a bc blank, recovery, a bp_en blank, recovery.
    wait_commits(4, 2600);
    bc = 1'b1;
    wait_commits(5, 700);
    bc = 1'b0;
    wait_commits(6, 700);
    bp_en = 1'b0;
    wait_commits(7, 700);
    bp_en = 1'b1;
    wait_commits(8, 700);

    repeat (5) @(negedge clk);
    check_val("sb_empty", 64'(sb_q.size()), 64'(0));
    check_val("fd_count_model", 64'(fd_exp), 64'(1));
    check_val("fd_count", 64'(fd_seen), 64'(fd_exp));
    check_val("main_no_overrun", 64'(overrun), 64'(0));
    check_val("wrap_no_overrun", 64'(w_overrun), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
